// File: rtl/inv_qam_demap_if.sv
// Bus bundle for the QPSK hard-decision demapper: control requests,
// the qualified I/Q sample stream and the registered symbol outputs.
interface inv_qam_demap_if;
   logic              start;
   logic              stop;
   logic              in_valid;
   logic signed [7:0] i_sample;
   logic signed [7:0] q_sample;
   logic [1:0]        inv_QAM_out;
   logic              sym_valid;
   logic [4:0]        sym_index;
   logic              frame_start;
   logic              trigger_decode;

   modport master (
      output start, stop, in_valid, i_sample, q_sample,
      input  inv_QAM_out, sym_valid, sym_index, frame_start, trigger_decode
   );

   modport slave (
      input  start, stop, in_valid, i_sample, q_sample,
      output inv_QAM_out, sym_valid, sym_index, frame_start, trigger_decode
   );
endinterface

// File: rtl/inv_qam_demap.sv
// QPSK hard-decision demapper: integrates SPS samples per symbol on I and Q,
// decides each bit from the sign of the integrated sum, and tags symbols with
// their position in a FRAME_LEN-symbol decoder frame.
module inv_qam_demap #(
   parameter int SPS       = 4,
   parameter int FRAME_LEN = 31
) (
   input  logic           clk,
   input  logic           reset,
   inv_qam_demap_if.slave bus
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [3:0] LP_CNT_LAST = 4'(SPS - 1);
   localparam logic [4:0] LP_IDX_LAST = 5'(FRAME_LEN - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic signed [11:0] r_acc_i;
   logic signed [11:0] r_acc_q;
   logic signed [11:0] w_sum_i;
   logic signed [11:0] w_sum_q;
   logic [3:0]         r_cnt;
   logic [4:0]         r_idx;
   logic [1:0]         r_out;
   logic               r_sym_valid;
   logic [4:0]         r_sym_index;
   logic               r_frame_start;
   logic               r_trig;
   logic               w_accept;
   logic               w_done;
   logic               w_abort;

   // Hard decision: a strictly negative sum decides 1, zero and positive decide 0.
   function automatic logic f_decide(input logic signed [11:0] s);
      return s[11];
   endfunction

   // Running sums including the sample on the bus this cycle (sign-extended).
   assign w_sum_i = r_acc_i + {{4{bus.i_sample[7]}}, bus.i_sample};
   assign w_sum_q = r_acc_q + {{4{bus.q_sample[7]}}, bus.q_sample};

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state and per-cycle datapath strobes; stop beats start, and the start
   // cycle itself is still IDLE so its sample is not accepted.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start && !bus.stop) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (bus.stop) begin
               w_state_nxt = S_IDLE;
               w_abort     = 1'b1;
            end else if (bus.in_valid) begin
               w_accept = 1'b1;
               w_done   = (r_cnt == LP_CNT_LAST);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Accumulation, symbol decision and frame position tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc_i       <= '0;
         r_acc_q       <= '0;
         r_cnt         <= '0;
         r_idx         <= '0;
         r_out         <= '0;
         r_sym_valid   <= 1'b0;
         r_sym_index   <= '0;
         r_frame_start <= 1'b0;
         r_trig        <= 1'b0;
      end else begin
         r_sym_valid   <= 1'b0;
         r_frame_start <= 1'b0;
         if (w_abort) begin
            // Partial symbol is dropped and the frame restarts from index 0.
            r_acc_i     <= '0;
            r_acc_q     <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_sym_index <= '0;
            r_trig      <= 1'b0;
         end else if (w_done) begin
            r_out         <= {f_decide(w_sum_i), f_decide(w_sum_q)};
            r_sym_valid   <= 1'b1;
            r_sym_index   <= r_idx;
            r_frame_start <= (r_idx == 5'd0);
            r_idx         <= (r_idx == LP_IDX_LAST) ? 5'd0 : r_idx + 5'd1;
            r_trig        <= 1'b1;
            r_acc_i       <= '0;
            r_acc_q       <= '0;
            r_cnt         <= '0;
         end else if (w_accept) begin
            r_acc_i <= w_sum_i;
            r_acc_q <= w_sum_q;
            r_cnt   <= r_cnt + 4'd1;
         end else if (r_state == S_IDLE) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_cnt   <= '0;
            r_trig  <= 1'b0;
         end
      end
   end

   assign bus.inv_QAM_out    = r_out;
   assign bus.sym_valid      = r_sym_valid;
   assign bus.sym_index      = r_sym_index;
   assign bus.frame_start    = r_frame_start;
   assign bus.trigger_decode = r_trig;

endmodule

// File: tb/tb_inv_qam_demap.sv
// Self-checking bench for inv_qam_demap: an integer-level symbol model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_inv_qam_demap;
   localparam int SPS       = 4;
   localparam int FRAME_LEN = 31;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   logic chk_en = 1'b0;

   inv_qam_demap_if bus();

   inv_qam_demap #(.SPS(SPS), .FRAME_LEN(FRAME_LEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic m_run;
   int   m_n, m_si, m_sq, m_idx;
   logic [1:0] e_out;
   logic e_sv, e_fs, e_trig;
   logic [4:0] e_idx;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic sp, input logic v,
                        input logic signed [7:0] i, input logic signed [7:0] q);
      @(posedge clk);
      #1;
      bus.start    = st;
      bus.stop     = sp;
      bus.in_valid = v;
      bus.i_sample = i;
      bus.q_sample = q;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 8'sd0, 8'sd0);
   endtask

   // Symbol-level model: sums whole symbols with plain integers.
   always @(posedge clk) begin
      if (reset) begin
         m_run = 1'b0; m_n = 0; m_si = 0; m_sq = 0; m_idx = 0;
         e_out = 2'b00; e_sv = 1'b0; e_idx = 5'd0; e_fs = 1'b0; e_trig = 1'b0;
      end else begin
         e_sv = 1'b0;
         e_fs = 1'b0;
         if (m_run) begin
            if (bus.stop) begin
               m_run = 1'b0; m_n = 0; m_si = 0; m_sq = 0; m_idx = 0;
               e_idx = 5'd0; e_trig = 1'b0;
            end else if (bus.in_valid) begin
               m_si += int'(bus.i_sample);
               m_sq += int'(bus.q_sample);
               m_n++;
               if (m_n == SPS) begin
                  e_out  = {(m_si < 0), (m_sq < 0)};
                  e_sv   = 1'b1;
                  e_idx  = 5'(m_idx);
                  e_fs   = (m_idx == 0);
                  e_trig = 1'b1;
                  m_idx  = (m_idx + 1) % FRAME_LEN;
                  m_n = 0; m_si = 0; m_sq = 0;
               end
            end
         end else if (bus.start && !bus.stop) begin
            m_run = 1'b1;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_out",   32'(bus.inv_QAM_out),    32'(e_out));
         chk("model_sv",    32'(bus.sym_valid),      32'(e_sv));
         chk("model_idx",   32'(bus.sym_index),      32'(e_idx));
         chk("model_fs",    32'(bus.frame_start),    32'(e_fs));
         chk("model_trig",  32'(bus.trigger_decode), 32'(e_trig));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int sv_seen;
      int n_sym;
      int pos[32];
      int idxs[32];
      int fss[32];
      bus.start = 1'b0; bus.stop = 1'b0; bus.in_valid = 1'b0;
      bus.i_sample = 8'sd0; bus.q_sample = 8'sd0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out",  32'(bus.inv_QAM_out), 32'd0);
      chk("rst_sv",   32'(bus.sym_valid), 32'd0);
      chk("rst_idx",  32'(bus.sym_index), 32'd0);
      chk("rst_fs",   32'(bus.frame_start), 32'd0);
      chk("rst_trig", 32'(bus.trigger_decode), 32'd0);
      reset = 1'b0;
      chk_en = 1'b1;

      // First symbol; the sample presented with start must be ignored
      drive(1'b1, 1'b0, 1'b1, -8'sd100, 8'sd100);
      drive(1'b0, 1'b0, 1'b1, 8'sd20, -8'sd30);
      drive(1'b0, 1'b0, 1'b1, -8'sd5, 8'sd4);
      drive(1'b0, 1'b0, 1'b1, 8'sd10, -8'sd1);
      drive(1'b0, 1'b0, 1'b1, 8'sd3, 8'sd2);
      chk("trig_before_first", 32'(bus.trigger_decode), 32'd0);
      idle();
      chk("s1_out",  32'(bus.inv_QAM_out), 32'd1);
      chk("s1_sv",   32'(bus.sym_valid), 32'd1);
      chk("s1_idx",  32'(bus.sym_index), 32'd0);
      chk("s1_fs",   32'(bus.frame_start), 32'd1);
      chk("s1_trig", 32'(bus.trigger_decode), 32'd1);

      // I sum exactly zero decides 0, Q sum -1 decides 1
      drive(1'b0, 1'b0, 1'b1, 8'sd5, 8'sd0);
      drive(1'b0, 1'b0, 1'b1, -8'sd5, 8'sd0);
      drive(1'b0, 1'b0, 1'b1, 8'sd7, 8'sd0);
      drive(1'b0, 1'b0, 1'b1, -8'sd7, -8'sd1);
      idle();
      chk("zero_out", 32'(bus.inv_QAM_out), 32'd1);
      chk("zero_sv",  32'(bus.sym_valid), 32'd1);
      chk("zero_idx", 32'(bus.sym_index), 32'd1);
      chk("zero_fs",  32'(bus.frame_start), 32'd0);
      idle();
      chk("hold_sv",  32'(bus.sym_valid), 32'd0);
      chk("hold_out", 32'(bus.inv_QAM_out), 32'd1);

      // Gapped in_valid: 1,0,0,1,1,0,1
      sv_seen = 0;
      begin
         logic [6:0] pat;
         pat = 7'b1011001; // LSB first: 1,0,0,1,1,0,1
         for (int k = 0; k < 7; k++) begin
            drive(1'b0, 1'b0, pat[k], -8'sd1, 8'sd1);
            if (bus.sym_valid) sv_seen++;
         end
      end
      idle();
      chk("gap_early_sv", 32'(sv_seen), 32'd0);
      chk("gap_sv",   32'(bus.sym_valid), 32'd1);
      chk("gap_out",  32'(bus.inv_QAM_out), 32'd2);
      chk("gap_idx",  32'(bus.sym_index), 32'd2);
      idle();
      chk("gap_once", 32'(bus.sym_valid), 32'd0);

      // Stop, restart and run 32 back-to-back symbols across the frame wrap
      drive(1'b0, 1'b1, 1'b0, 8'sd0, 8'sd0);
      idle();
      chk("stop_trig", 32'(bus.trigger_decode), 32'd0);
      chk("stop_idx",  32'(bus.sym_index), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 8'sd0, 8'sd0);
      n_sym = 0;
      for (int c = 0; c <= 128; c++) begin
         drive(1'b0, 1'b0, (c < 128), 8'sd1, -8'sd1);
         if (bus.sym_valid) begin
            if (n_sym < 32) begin
               pos[n_sym]  = c;
               idxs[n_sym] = int'(bus.sym_index);
               fss[n_sym]  = int'(bus.frame_start);
            end
            n_sym++;
         end
      end
      chk("frame_count", 32'(n_sym), 32'd32);
      if (n_sym >= 32) begin
         for (int k = 0; k < 32; k++) begin
            chk("frame_idx", 32'(idxs[k]), 32'(k % FRAME_LEN));
            chk("frame_pos", 32'(pos[k]), 32'(4 * (k + 1)));
         end
         chk("frame_30",   32'(idxs[30]), 32'd30);
         chk("frame_wrap_fs", 32'(fss[31]), 32'd1);
         chk("frame_mid_fs",  32'(fss[15]), 32'd0);
      end

      // Stop mid-symbol, then restart with -128 samples
      drive(1'b0, 1'b0, 1'b1, 8'sd50, 8'sd50);
      drive(1'b0, 1'b0, 1'b1, 8'sd50, 8'sd50);
      drive(1'b0, 1'b1, 1'b0, 8'sd0, 8'sd0);
      idle();
      chk("abort_sv",   32'(bus.sym_valid), 32'd0);
      chk("abort_trig", 32'(bus.trigger_decode), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 8'sd0, 8'sd0);
      for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 1'b1, -8'sd128, -8'sd128);
      chk("abort_trig_low", 32'(bus.trigger_decode), 32'd0);
      idle();
      chk("neg_out",  32'(bus.inv_QAM_out), 32'd3);
      chk("neg_sv",   32'(bus.sym_valid), 32'd1);
      chk("neg_idx",  32'(bus.sym_index), 32'd0);
      chk("neg_fs",   32'(bus.frame_start), 32'd1);
      chk("neg_trig", 32'(bus.trigger_decode), 32'd1);

      // Reset mid-symbol with start and stop both high
      drive(1'b0, 1'b0, 1'b1, -8'sd9, -8'sd9);
      drive(1'b0, 1'b0, 1'b1, -8'sd9, -8'sd9);
      drive(1'b1, 1'b1, 1'b1, 8'sd9, 8'sd9);
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b1, -8'sd20, -8'sd20);
      reset = 1'b0;
      chk("mrst_out",  32'(bus.inv_QAM_out), 32'd0);
      chk("mrst_sv",   32'(bus.sym_valid), 32'd0);
      chk("mrst_idx",  32'(bus.sym_index), 32'd0);
      chk("mrst_fs",   32'(bus.frame_start), 32'd0);
      chk("mrst_trig", 32'(bus.trigger_decode), 32'd0);
      sv_seen = 0;
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b0, 1'b1, -8'sd20, -8'sd20);
         if (bus.sym_valid) sv_seen++;
      end
      chk("idle_ignores", 32'(sv_seen), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 8'sd0, 8'sd0);
      for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 1'b1, -8'sd1, 8'sd1);
      idle();
      chk("restart_sv",  32'(bus.sym_valid), 32'd1);
      chk("restart_idx", 32'(bus.sym_index), 32'd0);
      chk("restart_fs",  32'(bus.frame_start), 32'd1);
      chk("restart_out", 32'(bus.inv_QAM_out), 32'd2);
      idle();
      idle();

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/inv_qam_demap.md
INV_QAM_DEMAP -- requirements
Module: inv_qam_demap

Interface
REQ-001 SHALL have parameter SPS, default 4; samples per symbol, legal range 1..16.
REQ-002 SHALL have parameter FRAME_LEN, default 31; symbols per decoder frame, legal range 2..32.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin demapping.
REQ-006 SHALL have port stop  input  1  one-cycle request to return to idle.
REQ-007 SHALL have port in_valid  input  1  qualifies i_sample and q_sample.
REQ-008 SHALL have port i_sample  input  8  signed two's-complement in-phase sample.
REQ-009 SHALL have port q_sample  input  8  signed two's-complement quadrature sample.
REQ-010 SHALL have port inv_QAM_out  output  2  hard-decision QPSK symbol: bit1 from I, bit0 from Q.
REQ-011 SHALL have port sym_valid  output  1  one-cycle pulse when inv_QAM_out updates.
REQ-012 SHALL have port sym_index  output  5  position of the current symbol in the frame, 0..FRAME_LEN-1.
REQ-013 SHALL have port frame_start  output  1  pulse coincident with sym_valid when sym_index is 0.
REQ-014 SHALL have port trigger_decode  output  1  level that enables the downstream Viterbi decoder.

Function
REQ-015 SHALL implement two states:
- IDLE -> RUN on start=1.
- RUN -> IDLE on stop=1.
- When start and stop are asserted in the same cycle, stop wins.
- start asserted while in RUN is ignored.
REQ-016 SHALL, in RUN, accept a sample on each cycle with in_valid=1 and add it, sign-extended, into 12-bit signed accumulators acc_i and acc_q.
REQ-017 SHALL, when in_valid=0, hold the accumulators and the sample counter unchanged.
REQ-018 SHALL use a sample counter 0..SPS-1; the sample accepted at count SPS-1 completes the symbol and the counter wraps to 0.
REQ-019 SHALL, on symbol completion, base the decision on the final sum including that sample:
- inv_QAM_out[1] = 1 when the I sum is < 0, else 0.
- inv_QAM_out[0] = 1 when the Q sum is < 0, else 0.
- A sum of exactly 0 decides 0.
REQ-020 SHALL register the symbol-completion outputs so that inv_QAM_out, sym_valid and sym_index update on the clock edge after the completing sample is accepted (latency 1 cycle).
REQ-021 SHALL clear both accumulators to 0 on symbol completion; the next sample starts a fresh sum.
REQ-022 SHALL never overflow the 12-bit accumulators: the worst case is 16 x (-128) = -2048.
REQ-023 SHALL hold inv_QAM_out between sym_valid pulses.
REQ-024 SHALL increment sym_index after each emitted symbol and wrap it from FRAME_LEN-1 to 0.
REQ-025 SHALL have the first symbol after entering RUN carry sym_index 0 with frame_start=1.
REQ-026 SHALL set trigger_decode to 1 together with the first sym_valid in RUN, hold it at 1 while in RUN, and clear it to 0 on the cycle after entering IDLE.
REQ-027 SHALL, on stop in the middle of a symbol, discard the partial symbol:
- No sym_valid is produced for it.
- Accumulators, sample counter and sym_index are cleared to 0.
REQ-028 SHALL ignore in_valid in IDLE; the accumulators stay at 0.
REQ-029 SHALL treat the cycle in which start is sampled as still IDLE; a sample presented in that cycle is not accumulated.

Reset
REQ-030 SHALL, with reset=1 at a rising clk edge, enter IDLE and set inv_QAM_out=0, sym_valid=0, sym_index=0, frame_start=0, trigger_decode=0, accumulators=0 and the sample counter=0.
REQ-031 SHALL give reset priority over start, stop and in_valid, including when reset is asserted mid-symbol in RUN.

Verification
REQ-032 SHALL be checked with: SPS=4, start, then 4 valid samples I=+20,-5,+10,+3 and Q=-30,+4,-1,+2 -> one cycle later inv_QAM_out=2'b01, sym_valid=1, sym_index=0, frame_start=1, trigger_decode=1.
REQ-033 SHALL be checked with: I sum exactly 0 (+5,-5,+7,-7) and Q sum -1 -> inv_QAM_out=2'b01.
REQ-034 SHALL be checked with: 31 consecutive symbols, then one more -> the 32nd has sym_index=0 and frame_start=1; sym_index reaches 30 with no gap.
REQ-035 SHALL be checked with: in_valid toggled 1,0,0,1,1,0,1 -> exactly one sym_valid, on the cycle after the 4th valid sample.
REQ-036 SHALL be checked with: stop after 2 samples of a symbol, then start and 4 samples of -128 -> no symbol from the partial data, the new symbol is 2'b11 with sym_index=0, and trigger_decode drops to 0 in between.
REQ-037 SHALL be checked with: reset pulsed mid-frame while start and stop are both 1 -> all outputs 0, state IDLE, and start alone afterwards restarts at sym_index 0.
